mux_arbiter: RTL
================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester path and the output bus.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_a  input  1  requester A has a word pending.
REQ-005 data_a  input  WIDTH  requester A word.
REQ-006 ack_a  output  1  requester A word accepted this cycle.
REQ-007 req_b  input  1  requester B has a word pending.
REQ-008 data_b  input  WIDTH  requester B word.
REQ-009 ack_b  output  1  requester B word accepted this cycle.
REQ-010 out_valid  output  1  shared bus carries a granted word.
REQ-011 out_ready  input  1  consumer accepts the bus word this cycle.
REQ-012 out_data  output  WIDTH  shared bus word, selected through the 2:1 mux datapath.
REQ-013 grant_b  output  1  current mux select: 0 = A path, 1 = B path.

Function
REQ-014 State register SHALL hold one of IDLE, GNT_A, GNT_B; a 1-bit last pointer SHALL record the most recently served requester (0 = A, 1 = B).
REQ-015 grant_b SHALL be 1 in GNT_B and 0 in IDLE and GNT_A; it SHALL be driven from registered state only, with no combinational path from req/out_ready.
REQ-016 out_data SHALL equal data_a when grant_b = 0 and data_b when grant_b = 1, in every state including IDLE.
REQ-017 out_valid SHALL be 1 in GNT_A and GNT_B, and 0 in IDLE.
REQ-018 Transfer SHALL occur in a cycle where out_valid = 1 and out_ready = 1.
REQ-019 ack_a = (state == GNT_A) & out_ready; ack_b = (state == GNT_B) & out_ready; both are combinational and never high together.
REQ-020 From IDLE: only req_a -> GNT_A; only req_b -> GNT_B; both -> the requester not equal to last; neither -> stay IDLE.
REQ-021 A grant SHALL be held across any number of cycles with out_ready = 0 (no preemption while the word is pending).
REQ-022 On transfer from GNT_A: last <= A; next state = GNT_B if req_b, else GNT_A if req_a, else IDLE. Symmetric rule for GNT_B. This gives back-to-back words with no idle bubble.
REQ-023 Requesters SHALL hold req and data stable from assertion until their ack.
REQ-024 If the granted requester drops req before transfer, the state SHALL go to IDLE on the next edge, no ack SHALL be issued, and last SHALL be unchanged.
REQ-025 Under continuous requests from both sides, grants SHALL strictly alternate A, B, A, B; no requester SHALL wait more than one transfer of the other.
REQ-026 The arbiter SHALL NOT inspect or modify data; width and content pass through unchanged.

Reset
REQ-027 rst_n = 0 SHALL immediately force state = IDLE and last = B, independent of clk.
REQ-028 While and after reset: out_valid = 0, ack_a = ack_b = 0, grant_b = 0, out_data = data_a.
REQ-029 A reset asserted mid-grant SHALL abandon the pending word without an ack; the first grant after release SHALL favour A if both request.
REQ-030 Reset release SHALL take effect at the first rising clk edge with rst_n = 1; no transfer occurs in the release cycle.

Verification
REQ-031 After reset, req_a = req_b = 1, data_a = 8'h11, data_b = 8'h22, out_ready = 1 for 4 cycles -> out_data sequence 11, 22, 11, 22; acks alternate starting with ack_a.
REQ-032 Only req_b = 1, data_b = 8'h5A, out_ready = 0 for 3 cycles then 1 -> grant_b = 1 and out_valid = 1 throughout, out_data = 5A, and ack_b pulses once, on the ready cycle.
REQ-033 In GNT_A with out_ready = 0, raise req_b -> grant stays A until the A transfer, then GNT_B the next cycle.
REQ-034 In GNT_B, drop req_b with out_ready = 0 -> IDLE next cycle, no ack_b, and last is unchanged (verify the next simultaneous request is granted to A).
REQ-035 Assert rst_n = 0 asynchronously between edges during GNT_B -> out_valid and grant_b fall immediately, and no ack is produced.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter that drives a shared bus through a 2:1 mux.
// The mux select (grant_b) and out_valid are decoded from the state register
// only, so neither depends combinationally on req_* or out_ready. The acks are
// the only outputs that combine state with out_ready.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no grant; bus idle, mux parked on the A path
// GNT_A | A path on the bus, waiting for out_ready to transfer A's word
// GNT_B | B path on the bus, waiting for out_ready to transfer B's word
//
// last  | most recently served requester (0 = A, 1 = B); resets to B so
//       | that A wins the first contested grant after reset.

module mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,

    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             grant_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t state;
    logic   last;

    // Grant FSM and round-robin pointer; transfer takes priority over a
    // dropped request so a cycle that raised ack always updates last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= LAST_B;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a && req_b) begin
                        state <= (last == LAST_B) ? GNT_A : GNT_B;
                    end else if (req_a) begin
                        state <= GNT_A;
                    end else if (req_b) begin
                        state <= GNT_B;
                    end else begin
                        state <= IDLE;
                    end
                end

                GNT_A: begin
                    if (out_ready) begin
                        last <= LAST_A;
                        if (req_b) begin
                            state <= GNT_B;
                        end else if (req_a) begin
                            state <= GNT_A;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!req_a) begin
                        // Requester withdrew before transfer: abandon, keep last.
                        state <= IDLE;
                    end else begin
                        state <= GNT_A;
                    end
                end

                GNT_B: begin
                    if (out_ready) begin
                        last <= LAST_B;
                        if (req_a) begin
                            state <= GNT_A;
                        end else if (req_b) begin
                            state <= GNT_B;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!req_b) begin
                        state <= IDLE;
                    end else begin
                        state <= GNT_B;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Select and valid come straight from the state register.
    assign grant_b   = (state == GNT_B);
    assign out_valid = (state == GNT_A) || (state == GNT_B);

    // Datapath mux; in IDLE the select is 0 so the bus mirrors data_a.
    assign out_data  = grant_b ? data_b : data_a;

    // Acks mark the transfer cycle of the granted path; states are exclusive.
    assign ack_a     = (state == GNT_A) && out_ready;
    assign ack_b     = (state == GNT_B) && out_ready;

endmodule
